// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit with shift-in load, borrow-chained decrement and cancel.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  bcd_t load_data,
    input  logic dec,
    input  logic cancel,
    output bcd_t q,
    output logic borrow_out,
    output logic is_zero
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (cancel) begin
            q_d = '0;
        end else if (dec) begin
            q_d = (q_q == '0) ? MAX : q_q - 1'b1;
        end else if (load) begin
            q_d = load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign is_zero    = (q_q == '0);
    assign borrow_out = dec && (q_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: keyed BCD entry, seconds prescaler, start/stop FSM.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 100
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    load,
    input  logic [3:0]              data,
    input  logic                    start,
    input  logic                    stop,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    localparam int ND = MIN_DIGITS + 2;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    bcd_t          dig [ND];
    logic [ND:0]   borrow;
    logic [ND-1:0] dig_zero;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          zero_q, zero_d;
    logic          done_q, done_d;

    logic idle, go, cancel, shift, tick, term;

    always_comb begin
        idle   = (state_q == IDLE);
        go     = idle && start && !stop && !zero_q;
        cancel = idle && stop;
        shift  = idle && load && !stop && !go && (data <= BCD_MAX);
        tick   = !idle && !stop && (presc_q == PW'(TICK_DIV - 1));
        // last tick: only sec_ones==1 remains, so the decrement lands on all-zero
        term   = tick && (dig[0] == 4'd1) && (&dig_zero[ND-1:1]) && !borrow[ND];

        state_d = state_q;
        presc_d = '0;
        zero_d  = zero_q;
        done_d  = 1'b0;

        if (go) begin
            state_d = RUN;
            zero_d  = 1'b0;
        end

        if (!idle) begin
            if (stop) begin
                state_d = IDLE;
            end else if (term) begin
                state_d = IDLE;
                zero_d  = 1'b1;
                done_d  = 1'b1;
            end else if (!tick) begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (cancel) begin
            zero_d = 1'b1;
        end
        if (shift) begin
            zero_d = (data == 4'd0) && (&dig_zero[ND-2:0]);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            presc_q <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign borrow[0] = tick;

    bcd_down_digit #(.MAX(BCD_MAX)) u_sec_ones (
        .clock      (clock),
        .clear      (clear),
        .load       (shift),
        .load_data  (data),
        .dec        (borrow[0]),
        .cancel     (cancel),
        .q          (dig[0]),
        .borrow_out (borrow[1]),
        .is_zero    (dig_zero[0])
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock      (clock),
        .clear      (clear),
        .load       (shift),
        .load_data  (dig[0]),
        .dec        (borrow[1]),
        .cancel     (cancel),
        .q          (dig[1]),
        .borrow_out (borrow[2]),
        .is_zero    (dig_zero[1])
    );

    for (genvar k = 0; k < MIN_DIGITS; k++) begin : g_min
        bcd_down_digit #(.MAX(BCD_MAX)) u_min (
            .clock      (clock),
            .clear      (clear),
            .load       (shift),
            .load_data  (dig[k+1]),
            .dec        (borrow[k+2]),
            .cancel     (cancel),
            .q          (dig[k+2]),
            .borrow_out (borrow[k+3]),
            .is_zero    (dig_zero[k+2])
        );
        assign mins[4*k +: 4] = dig[k+2];
    end

    assign sec_ones = dig[0];
    assign sec_tens = dig[1];
    assign zero     = zero_q;
    assign running  = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_bcd_countdown_timer;

    localparam int MD = 2;
    localparam int TD = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          load  = 1'b0;
    logic [3:0]    data  = 4'd0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [3:0]    sec_ones;
    logic [3:0]    sec_tens;
    logic [4*MD-1:0] mins;
    logic          zero;
    logic          running;
    logic          done;

    bcd_countdown_timer #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .data     (data),
        .start    (start),
        .stop     (stop),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero),
        .running  (running),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // reference: minutes as a plain integer, seconds as two digits
    int m_ones = 0;
    int m_tens = 0;
    int m_mins = 0;
    int m_presc = 0;
    bit m_run = 0;
    bit m_done = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_zero();
        return (m_ones == 0) && (m_tens == 0) && (m_mins == 0);
    endfunction

    task automatic model_edge();
        if (clear) begin
            m_ones = 0; m_tens = 0; m_mins = 0;
            m_presc = 0; m_run = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (!m_run) begin
            if (stop) begin
                m_ones = 0; m_tens = 0; m_mins = 0;
            end else if (start && !m_is_zero()) begin
                m_run = 1; m_presc = 0;
            end else if (load && data <= 9) begin
                m_mins = (m_mins * 10 + m_tens) % 100;
                m_tens = m_ones;
                m_ones = int'(data);
            end
        end else begin
            if (stop) begin
                m_run = 0; m_presc = 0;
            end else if (m_presc == TD - 1) begin
                m_presc = 0;
                if (m_ones > 0) m_ones--;
                else begin
                    m_ones = 9;
                    if (m_tens > 0) m_tens--;
                    else begin
                        m_tens = 5;
                        m_mins--;
                    end
                end
                if (m_is_zero()) begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic step(input bit c, input bit l, input logic [3:0] d,
                        input bit st, input bit sp);
        clear = c; load = l; data = d; start = st; stop = sp;
        @(posedge clock);
        model_edge();
        #1;
        check("sec_ones", 32'(sec_ones), 32'(m_ones));
        check("sec_tens", 32'(sec_tens), 32'(m_tens));
        check("mins", 32'(mins), {24'd0, 4'(m_mins / 10), 4'(m_mins % 10)});
        check("zero", 32'(zero), 32'(m_is_zero()));
        check("running", 32'(running), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 0);
    endtask

    task automatic key(input logic [3:0] d);
        step(0, 1, d, 0, 0);
    endtask

    int first;
    int pulses;

    initial begin
        // reset and keyed entry
        step(1, 0, 4'd0, 0, 0);
        check("rst_zero", 32'(zero), 32'd1);
        key(4'd1); key(4'd3); key(4'd0);
        check("key_ones", 32'(sec_ones), 32'd0);
        check("key_tens", 32'(sec_tens), 32'd3);
        check("key_mins", 32'(mins), 32'h01);
        key(4'hA);
        check("key_bad", {sec_ones, sec_tens, mins}, 32'h0301);
        step(0, 0, 4'd0, 1, 0);
        idle_n(1);
        key(4'd5);
        check("key_run", {sec_ones, sec_tens, mins}, 32'h0301);
        step(1, 0, 4'd0, 0, 0);
        check("clr_mid", {sec_ones, sec_tens, mins, 2'b00, zero, running, done},
              32'h00004);

        // countdown with borrow
        key(4'd1); key(4'd0); key(4'd0);
        step(0, 0, 4'd0, 1, 0);
        idle_n(4);
        check("b_0059", {sec_ones, sec_tens, mins}, 32'h9500);
        idle_n(4);
        check("b_0058", {sec_ones, sec_tens, mins}, 32'h8500);
        step(1, 0, 4'd0, 0, 0);
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        step(0, 0, 4'd0, 1, 0);
        idle_n(4);
        check("b_0959", {sec_ones, sec_tens, mins}, 32'h9509);

        // terminal count
        step(1, 0, 4'd0, 0, 0);
        key(4'd2);
        step(0, 0, 4'd0, 1, 0);
        first = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            idle_n(1);
            if (done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("done_lat", 32'(first), 32'd8);
        check("done_cnt", 32'(pulses), 32'd1);
        step(0, 0, 4'd0, 1, 0);
        check("start_zero", 32'(running), 32'd0);

        // pause, resume, cancel
        step(1, 0, 4'd0, 0, 0);
        key(4'd3); key(4'd0);
        step(0, 0, 4'd0, 1, 0);
        idle_n(4);
        step(0, 0, 4'd0, 0, 1);
        check("pause", {sec_ones, sec_tens, 7'd0, running}, 32'h920000 >> 8);
        idle_n(3);
        check("held", {sec_ones, sec_tens}, 32'h92);
        step(0, 0, 4'd0, 1, 0);
        idle_n(2);
        check("resume", 32'(running), 32'd1);
        step(0, 0, 4'd0, 0, 1);
        step(0, 0, 4'd0, 0, 1);
        check("cancel", {sec_ones, sec_tens, mins, 3'd0, done}, 32'h00000);

        // entry "99" runs 99 ticks
        step(1, 0, 4'd0, 0, 0);
        key(4'd9); key(4'd9);
        step(0, 0, 4'd0, 1, 0);
        idle_n(4);
        check("s99", {sec_ones, sec_tens}, 32'h89);
        first = 0;
        for (int i = 1; i <= 500 && first == 0; i++) begin
            idle_n(1);
            if (done) first = i;
        end
        check("s99_end", 32'(first), 32'd392);

        // start+stop together in RUN pauses
        step(1, 0, 4'd0, 0, 0);
        key(4'd5);
        step(0, 0, 4'd0, 1, 0);
        idle_n(1);
        step(0, 0, 4'd0, 1, 1);
        check("ss_pause", {running, 3'd0, sec_ones}, 32'h05);

        // stop on the terminal tick
        step(1, 0, 4'd0, 0, 0);
        key(4'd1);
        step(0, 0, 4'd0, 1, 0);
        idle_n(3);
        step(0, 0, 4'd0, 0, 1);
        check("term_stop", {sec_ones, 2'd0, running, done}, 32'h10);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised successor of the microwave MM:SS countdown timer. Digits are keyed in one BCD digit at a time and shift into the display chain. The block has a configurable number of minute digits and a built-in seconds prescaler. It adds start/stop control, a pause/cancel mode and a one-cycle done pulse, and sits between the keypad decoder and the display/magnetron control FSM.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..4); maximum time is (10^MIN_DIGITS - 1):99.
TICK_DIV, 100, clock cycles per one-second decrement (>=1).

Ports:
clock  input  1  system clock; all logic on the rising edge.
clear  input  1  synchronous active-high reset.
load  input  1  shift data into the digit chain this cycle.
data  input  4  BCD keypad digit.
start  input  1  start or resume countdown.
stop  input  1  pause while running; cancel (zero all digits) while stopped.
sec_ones  output  4  seconds units digit.
sec_tens  output  4  seconds tens digit.
mins  output  4*MIN_DIGITS  minute digits, least-significant digit in [3:0].
zero  output  1  all digits are 0 (registered from the digit values).
running  output  1  state == RUN.
done  output  1  one-cycle pulse when the countdown reaches 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock = clock, reset = clear).
- Reset (clear=1 at an edge), which overrides every other input: all digits = 0, state = IDLE, prescaler = 0, zero = 1, running = 0, done = 0.
- FSM states:
  - IDLE: stopped or paused; digits hold.
  - RUN: counting down.
- Load (IDLE only; ignored in RUN; ignored if data > 9):
  - sec_ones <= data
  - sec_tens <= sec_ones
  - mins[3:0] <= sec_tens
  - mins[4k+3:4k] <= mins[4k-1:4k-4]
  - the MSD is discarded.
  - Digits are shifted unvalidated, so sec_tens may hold 6..9 (e.g. "99" = 99 s).
- IDLE transitions:
  - start=1, stop=0, zero=0 -> RUN; prescaler <= 0; running=1 from the next cycle.
  - start=1 with zero=1 is ignored.
- RUN transitions:
  - stop=1 -> IDLE (pause, digits held, prescaler <= 0).
  - start is ignored.
- IDLE with stop=1: all digits <= 0 (cancel).
- Priority: clear > stop > start > load. start and stop together means stop.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - The tick occurs when prescaler == TICK_DIV-1; the prescaler wraps to 0.
  - The first decrement lands TICK_DIV cycles after the edge that accepted start.
- Decrement (on tick):
  - sec_ones: if >0, -1; else 9 with borrow.
  - sec_tens (on borrow): if >0, -1; else 5 with borrow.
  - Each minute digit (on borrow): if >0, -1; else 9 with borrow.
  - Borrow out of the MSD cannot occur, because RUN is left at zero.
- Terminal count: when a tick produces all-zero digits, in the same edge: state <= IDLE, zero <= 1, done <= 1 for exactly one cycle.
- stop on the terminal tick edge: pause wins, digits are not decremented, no done pulse.
- zero and done are registered; done is never asserted outside the terminal edge or after clear.

Decomposition:
- Package timer_pkg:
  - BCD digit typedef (4-bit).
  - Constants BCD_MAX=9, SEC_TENS_MAX=5.
  - FSM state enum {IDLE, RUN}.
- Sub-module bcd_down_digit, parametrised on the wrap value MAX:
  - Ports: clock, clear, load, load_data, dec (borrow in), cancel, q, borrow_out, is_zero.
  - Instantiated once for sec_ones, once for sec_tens and MIN_DIGITS times in a generate loop.
  - The top level holds the FSM, prescaler and done/zero logic.

Test Plan:
All scenarios use MIN_DIGITS=2, TICK_DIV=4.
- Reset: clear=1 for one edge mid-RUN -> next cycle all digits 0, zero=1, running=0, done=0.
- Keyed entry: load 1,3,0 -> sec_ones=0, sec_tens=3, mins=8'h01. Load data=4'hA -> no change. Load during RUN -> no change.
- Countdown with borrow: from 01:00, start -> after 4 cycles 00:59, 4 more -> 00:58. From 10:00 the first tick gives 09:59.
- Terminal: 00:02, start -> done pulses high exactly once, 8 cycles after start acceptance; zero=1; running=0. A further start while zero is ignored.
- Pause/cancel: 00:30 running, stop after 1 tick -> 00:29 held, running=0. Start resumes. Stop again, then stop in IDLE -> 00:00, no done pulse.
- Edge cases:
  - Entry "99" counts 99 -> 98 and reaches 00 after 99 ticks.
  - start+stop together in RUN pauses.
  - stop on the terminal tick leaves 00:01 and no done.
